// File: rtl/lvds_tx_serializer_if.sv
// FIFO read-side bus between the TX FIFO and the LVDS TX serializer.
// The serializer is the master: it issues the pull strobe and receives the word.
interface lvds_tx_serializer_if;
    logic        o_fifo_pull;
    logic [31:0] i_fifo_pulled_data;
    logic        i_fifo_empty;

    modport master (
        output o_fifo_pull,
        input  i_fifo_pulled_data,
        input  i_fifo_empty
    );

    modport slave (
        input  o_fifo_pull,
        output i_fifo_pulled_data,
        output i_fifo_empty
    );
endinterface

// File: rtl/lvds_tx_serializer.sv
// LVDS TX serializer: turns 32-bit I/Q FIFO words into sync-framed 32-bit modem
// frames and emits them MSB-first as one dibit per clock toward a DDR output cell.
module lvds_tx_serializer #(
    parameter logic [1:0] SYNC_I    = 2'b10,
    parameter logic [1:0] SYNC_Q    = 2'b01,
    parameter logic [1:0] IDLE_BITS = 2'b00
) (
    input  logic                        i_sys_clk,
    input  logic                        i_rst,
    input  logic                        i_tx_enable,
    input  logic                        i_clear_stats,
    lvds_tx_serializer_if.master        fifo_bus,
    output logic [1:0]                  o_ddr_data,
    output logic                        o_frame_start,
    output logic                        o_busy,
    output logic [7:0]                  o_underrun_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_cnt;
    logic [29:0] r_shifter;
    logic        r_pfValid;
    logic [1:0]  r_ddrData;
    logic        r_frameStart;
    logic        r_busy;
    logic [7:0]  r_underrunCnt;

    logic        w_pull;
    logic        w_load;
    logic        w_underrun;
    logic        w_canPull;
    logic [31:0] w_frame;

    assign w_canPull = i_tx_enable && !fifo_bus.i_fifo_empty;
    assign w_frame   = {SYNC_I, fifo_bus.i_fifo_pulled_data[28:16], 1'b0,
                        SYNC_Q, fifo_bus.i_fifo_pulled_data[12:0],  1'b0};

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The prefetch pull at cnt 14 lets its word arrive exactly at cnt 15 for a gapless reload.
    always_comb begin
        w_nextState = r_state;
        w_pull      = 1'b0;
        w_load      = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_canPull) begin
                    w_pull      = 1'b1;
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                w_load      = 1'b1;
                w_nextState = SHIFT;
            end
            SHIFT: begin
                if (r_cnt == 4'd14) begin
                    w_pull = w_canPull;
                end else if (r_cnt == 4'd15) begin
                    if (r_pfValid) begin
                        w_load = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                        w_underrun  = i_tx_enable;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (i_rst) begin
            w_pull = 1'b0;
        end
    end

    assign fifo_bus.o_fifo_pull = w_pull;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_cnt         <= 4'd0;
            r_shifter     <= 30'd0;
            r_pfValid     <= 1'b0;
            r_ddrData     <= IDLE_BITS;
            r_frameStart  <= 1'b0;
            r_busy        <= 1'b0;
            r_underrunCnt <= 8'd0;
        end else begin
            r_busy       <= (w_nextState != IDLE);
            r_frameStart <= w_load;
            if (r_state == SHIFT && r_cnt == 4'd14) begin
                r_pfValid <= w_pull;
            end
            if (w_load) begin
                r_ddrData <= w_frame[31:30];
                r_shifter <= w_frame[29:0];
                r_cnt     <= 4'd0;
            end else if (r_state == SHIFT && r_cnt != 4'd15) begin
                r_ddrData <= r_shifter[29:28];
                r_shifter <= {r_shifter[27:0], 2'b00};
                r_cnt     <= r_cnt + 4'd1;
            end else begin
                r_ddrData <= IDLE_BITS;
                r_cnt     <= 4'd0;
            end
            // A coincident clear overrides the underrun increment.
            if (i_clear_stats) begin
                r_underrunCnt <= 8'd0;
            end else if (w_underrun && r_underrunCnt != 8'hFF) begin
                r_underrunCnt <= r_underrunCnt + 8'd1;
            end
        end
    end

    assign o_ddr_data     = r_ddrData;
    assign o_frame_start  = r_frameStart;
    assign o_busy         = r_busy;
    assign o_underrun_cnt = r_underrunCnt;

endmodule
